// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: constant log2, count-width sizing and parameter legality.
package fifo_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

    function automatic bit fifo_params_ok(input int unsigned depth,
                                          input int unsigned af_lvl,
                                          input int unsigned ae_lvl);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (af_lvl >= 1) && (af_lvl <= depth) && (ae_lvl <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer with async reset; clear takes priority over increment.
module fifo_ptr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_d, ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, almost flags, flush and sticky errors.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AF_LVL = 6,
    parameter int unsigned AE_LVL = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        io_din,
    input  logic                     io_push,
    input  logic                     io_pop,
    input  logic                     io_flush,
    output logic [DATA_W-1:0]        io_dout,
    output logic                     io_empty,
    output logic                     io_full,
    output logic                     io_almost_full,
    output logic                     io_almost_empty,
    output logic [cnt_w(DEPTH)-1:0]  io_count,
    output logic                     io_overflow,
    output logic                     io_underflow
);

    localparam int unsigned ADDR_W = clog2(DEPTH);
    localparam int unsigned CNT_W  = cnt_w(DEPTH);

    if (!fifo_params_ok(DEPTH, AF_LVL, AE_LVL)) begin : g_param_check
        $error("sync_fifo_param: illegal DEPTH/AF_LVL/AE_LVL combination");
    end

    logic [ADDR_W:0]     wr_ptr, rd_ptr;
    logic [ADDR_W-1:0]   wr_idx, rd_idx;
    logic                push_ok, pop_ok;
    logic                overflow_d, overflow_q;
    logic                underflow_d, underflow_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    assign wr_idx = wr_ptr[ADDR_W-1:0];
    assign rd_idx = rd_ptr[ADDR_W-1:0];

    assign io_empty = (wr_ptr == rd_ptr);
    assign io_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_idx == rd_idx);
    assign io_count = wr_ptr - rd_ptr;

    assign io_almost_full  = (io_count >= CNT_W'(AF_LVL));
    assign io_almost_empty = (io_count <= CNT_W'(AE_LVL));

    // A pop frees the head slot, so a push may proceed while full in the same cycle.
    assign pop_ok  = io_pop & ~io_flush & ~io_empty;
    assign push_ok = io_push & ~io_flush & (~io_full | pop_ok);

    fifo_ptr #(
        .W (ADDR_W + 1)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc_i (push_ok),
        .clr_i (io_flush),
        .ptr_o (wr_ptr)
    );

    fifo_ptr #(
        .W (ADDR_W + 1)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc_i (pop_ok),
        .clr_i (io_flush),
        .ptr_o (rd_ptr)
    );

    always_comb begin
        overflow_d  = overflow_q | (io_push & ~push_ok);
        underflow_d = underflow_q | (io_pop & ~pop_ok);
        if (io_flush) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_idx] <= io_din;
        end
    end

    assign io_dout      = mem_q[rd_idx];
    assign io_overflow  = overflow_q;
    assign io_underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param at DATA_W=8, DEPTH=4, AF_LVL=3, AE_LVL=1.
module tb_sync_fifo_param;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned AF_LVL = 3;
    localparam int unsigned AE_LVL = 1;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] io_din;
    logic              io_push;
    logic              io_pop;
    logic              io_flush;
    logic [DATA_W-1:0] io_dout;
    logic              io_empty;
    logic              io_full;
    logic              io_almost_full;
    logic              io_almost_empty;
    logic [2:0]        io_count;
    logic              io_overflow;
    logic              io_underflow;

    int unsigned       checks;
    int unsigned       failures;
    logic [7:0]        sb [$];
    bit                exp_ov;
    bit                exp_uf;

    sync_fifo_param #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AF_LVL (AF_LVL),
        .AE_LVL (AE_LVL)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .io_din          (io_din),
        .io_push         (io_push),
        .io_pop          (io_pop),
        .io_flush        (io_flush),
        .io_dout         (io_dout),
        .io_empty        (io_empty),
        .io_full         (io_full),
        .io_almost_full  (io_almost_full),
        .io_almost_empty (io_almost_empty),
        .io_count        (io_count),
        .io_overflow     (io_overflow),
        .io_underflow    (io_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_status(input string tag);
        int n;
        n = sb.size();
        check_eq({tag, ".count"}, 32'(io_count), 32'(n));
        check_eq({tag, ".empty"}, 32'(io_empty), 32'(n == 0));
        check_eq({tag, ".full"}, 32'(io_full), 32'(n == DEPTH));
        check_eq({tag, ".afull"}, 32'(io_almost_full), 32'(n >= AF_LVL));
        check_eq({tag, ".aempty"}, 32'(io_almost_empty), 32'(n <= AE_LVL));
        check_eq({tag, ".ovf"}, 32'(io_overflow), 32'(exp_ov));
        check_eq({tag, ".udf"}, 32'(io_underflow), 32'(exp_uf));
        if (n != 0) begin
            check_eq({tag, ".head"}, 32'(io_dout), 32'(sb[0]));
        end
    endtask

    // Drive one clock of stimulus, score it against the model, then check status.
    task automatic cycle(input string tag, input bit push, input bit pop, input bit flush,
                         input logic [7:0] din);
        bit pop_ok;
        bit push_ok;
        io_push  = push;
        io_pop   = pop;
        io_flush = flush;
        io_din   = din;
        #1;
        pop_ok  = pop && (sb.size() != 0);
        push_ok = push && ((sb.size() != DEPTH) || pop_ok);
        if (flush) begin
            sb.delete();
            exp_ov = 1'b0;
            exp_uf = 1'b0;
        end else begin
            if (push && !push_ok) exp_ov = 1'b1;
            if (pop && !pop_ok) exp_uf = 1'b1;
            if (pop_ok) check_eq({tag, ".pop"}, 32'(io_dout), 32'(sb.pop_front()));
            if (push_ok) sb.push_back(din);
        end
        @(posedge clk);
        #1;
        io_push  = 1'b0;
        io_pop   = 1'b0;
        io_flush = 1'b0;
        check_status(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_ov   = 1'b0;
        exp_uf   = 1'b0;
        io_push  = 1'b0;
        io_pop   = 1'b0;
        io_flush = 1'b0;
        io_din   = '0;
        reset    = 1'b1;
        #12;
        check_status("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: fill in order, then drain
        for (int i = 0; i < 4; i++) cycle("t1.push", 1, 0, 0, 8'hA0 + 8'(i));
        for (int i = 0; i < 4; i++) cycle("t1.pop", 0, 1, 0, 8'h00);

        // 2: overflow while full, then push+pop while full
        for (int i = 0; i < 4; i++) cycle("t2.fill", 1, 0, 0, 8'hA0 + 8'(i));
        cycle("t2.ovf", 1, 0, 0, 8'h55);
        cycle("t2.pp", 1, 1, 0, 8'h66);
        for (int i = 0; i < 4; i++) cycle("t2.drain", 0, 1, 0, 8'h00);

        // 3: underflow on empty, then push+pop while empty
        cycle("t3.udf", 0, 1, 0, 8'h00);
        cycle("t3.pp", 1, 1, 0, 8'h11);
        cycle("t3.pop", 0, 1, 0, 8'h00);

        // 4: nine entries through depth 4, wrapping the pointers
        cycle("t4.flush", 0, 0, 1, 8'h00);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) cycle("t4.fill", 1, 0, 0, 8'h30 + 8'(r * 4 + i));
            for (int i = 0; i < 4; i++) cycle("t4.drain", 0, 1, 0, 8'h00);
        end
        cycle("t4.last", 1, 0, 0, 8'h38);
        cycle("t4.lpop", 0, 1, 0, 8'h00);

        // 5: flush wins over a same-cycle push and clears sticky flags
        for (int i = 0; i < 4; i++) cycle("t5.fill", 1, 0, 0, 8'hC0 + 8'(i));
        cycle("t5.ovf", 1, 0, 0, 8'hEE);
        cycle("t5.pop", 0, 1, 0, 8'h00);
        cycle("t5.flush", 1, 0, 1, 8'hDD);

        // Random mix against the scoreboard
        for (int i = 0; i < 60; i++) begin
            cycle("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0), 8'($urandom));
        end

        // 6: async reset between edges empties the FIFO at once
        cycle("t6.flush", 0, 0, 1, 8'h00);
        cycle("t6.a", 1, 0, 0, 8'h21);
        cycle("t6.b", 1, 0, 0, 8'h22);
        #3;
        reset = 1'b1;
        #1;
        sb.delete();
        exp_ov = 1'b0;
        exp_uf = 1'b0;
        check_status("t6.rst");
        #2;
        reset = 1'b0;
        cycle("t6.push", 1, 0, 0, 8'h77);
        check_eq("t6.entry0", 32'(dut.mem_q[0]), 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
